bwt_occ_responder: RTL and testbench
====================================

Name: bwt_occ_responder

Overview:
- Memory-side responder for the backward-extension occurrence-request stage.
- Accepts one request per handshake, carrying line addresses addr_k/addr_l plus an opaque tag (read_num, pipeline token).
- Fetches both 512-bit BWT occurrence lines through a single in-order read port, pairs them, and returns them with the tag to the occurrence-calculation stage.
- Buffers requests so the issuing stage stalls only when the buffer is full.

Parameters:
- ADDR_W, 42, line address width; matches addr_k/addr_l.
- LINE_W, 512, occurrence line width in bits.
- TAG_W, 16, opaque request tag width; passed through unchanged.
- DEPTH, 4, request FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_addr_k  in  ADDR_W  k line address
- req_addr_l  in  ADDR_W  l line address
- req_tag  in  TAG_W  opaque tag
- mem_rd_valid  out  1  read command valid
- mem_rd_addr  out  ADDR_W  read line address
- mem_rd_ready  in  1  memory accepts command
- mem_rsp_valid  in  1  read data valid; in order, no backpressure
- mem_rsp_data  in  LINE_W  read data
- rsp_valid  out  1  paired result valid
- rsp_ready  in  1  downstream accepts (inverse of stall)
- rsp_data_k  out  LINE_W  k line
- rsp_data_l  out  LINE_W  l line
- rsp_tag  out  TAG_W  tag of the request
- err_unexp  out  1  sticky: memory response with nothing outstanding

Behaviour:
- Reset (rst low, async): FIFO empty, FSM in IDLE, all outputs 0, req_ready 0 during reset. After release, req_ready = !fifo_full.
- FIFO:
  - Push on req_valid && req_ready.
  - Pushed entry is visible at the head the next cycle; no same-cycle bypass.
  - Push and pop in the same cycle are legal when full; req_ready does not use pop look-ahead.
- FSM states: IDLE, ISSUE_K, ISSUE_L, WAIT, OUT.
  - IDLE: if FIFO non-empty, pop the head into registers addr_k/addr_l/tag and clear rcnt; go to ISSUE_K.
  - ISSUE_K: mem_rd_valid=1, mem_rd_addr=addr_k. On mem_rd_ready, go to ISSUE_L.
  - ISSUE_L: mem_rd_valid=1, mem_rd_addr=addr_l. On mem_rd_ready, go to WAIT.
  - WAIT: once rcnt reaches the needed count (2 normally), go to OUT.
  - OUT: rsp_valid=1 with data and tag held stable. On rsp_ready, go to IDLE.
  - rsp_valid and mem_rd_valid are both deasserted in all other states.
- Response capture:
  - Accepted in ISSUE_L, WAIT and ISSUE_K after the k command.
  - The first response is written to data_k, the second to data_l; rcnt is 2 bits and saturates at the needed count.
  - A response in ISSUE_L is legal: the k line can return while the l command is stalled.
- Only one request pair is outstanding at a time. No data buffering beyond data_k/data_l, and no response can be dropped.
- A response with nothing outstanding (rcnt already at the needed count, or state IDLE/OUT, or ISSUE_K before the k command is accepted): data discarded, err_unexp set. err_unexp clears only on reset.
- Latency with mem_rd_ready=1 and 1-cycle memory, request accepted at cycle T:
  - mem_rd k at T+2, l at T+3.
  - data k at T+3, l at T+4.
  - rsp_valid at T+5.
  - Throughput is one pair per 5 cycles when memory and downstream are ideal.
- rsp_ready held low: the FSM stays in OUT; the FIFO keeps accepting until full.
- Reset mid-operation: in-flight state is lost. The memory subsystem is reset with this block; stale responses arriving after reset set err_unexp.

Optional Feature:
- Macro: SMEM_OCC_SAME_LINE_DEDUP_EN.
- Defined: if the latched addr_k == addr_l, ISSUE_K goes directly to WAIT after the k command. The needed count is 1, and the single response is written to both data_k and data_l.
- Undefined: two commands are always issued, even for equal addresses.
- The interface is identical in both builds.

Decomposition:
- Package smem_pkg holds:
  - ADDR_W and LINE_W defaults.
  - A typedef for the FSM state enum, with localparams IDLE=0, ISSUE_K=1, ISSUE_L=2, WAIT=3, OUT=4.
  - A typedef for the request-entry struct {addr_k, addr_l, tag}.
- One sub-module, occ_req_fifo: synchronous FIFO with async active-low reset, parameterised on DEPTH and entry width, exposing full/empty/push/pop/head.

Test Plan:
- Single request addr_k=0x100, addr_l=0x180, tag=0x2A; ideal memory returning A then B → rsp_valid at T+5 with data_k=A, data_l=B, rsp_tag=0x2A; exactly two mem_rd commands, at 0x100 then 0x180.
- Push 5 requests back-to-back with rsp_ready=0 and DEPTH=4 → req_ready low after the first pop frees nothing (4 entries held plus 1 in FSM). After releasing rsp_ready, all 5 tags return in order.
- mem_rd_ready low for 3 cycles during ISSUE_L while the k response arrives → data_k captured correctly; the l command issues once ready rises; result is correct.
- addr_k=addr_l=0x200 → with DEDUP_EN, one command and data_k=data_l; without it, two commands.
- mem_rsp_valid pulsed while IDLE → err_unexp=1 and stays 1. Then assert rst low mid-WAIT → all outputs 0 asynchronously and FIFO empty.

Source files
------------

// File: rtl/smem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : smem_pkg                                                   |
// | Shared widths, FSM state encoding and request-entry layout for the   |
// | BWT occurrence responder.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package smem_pkg;

  localparam int DEF_ADDR_W = 42;
  localparam int DEF_LINE_W = 512;
  localparam int DEF_TAG_W  = 16;

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_ISSUE_K = 3'd1;
  localparam logic [2:0] C_ST_ISSUE_L = 3'd2;
  localparam logic [2:0] C_ST_WAIT    = 3'd3;
  localparam logic [2:0] C_ST_OUT     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = C_ST_IDLE,
    ISSUE_K = C_ST_ISSUE_K,
    ISSUE_L = C_ST_ISSUE_L,
    WAIT    = C_ST_WAIT,
    OUT     = C_ST_OUT
  } occ_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr_k;
    logic [DEF_ADDR_W-1:0] addr_l;
    logic [DEF_TAG_W-1:0]  tag;
  } occ_req_t;

  localparam logic [1:0] C_RCNT_SINGLE = 2'd1;
  localparam logic [1:0] C_RCNT_PAIR   = 2'd2;

  // Response counter step that never runs past the number of lines expected.
  function automatic logic [1:0] rcnt_inc(input logic [1:0] cnt, input logic [1:0] lim);
    return (cnt >= lim) ? lim : cnt + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/occ_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : occ_req_fifo                                               |
// | Synchronous request FIFO, async active-low reset, no bypass path.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module occ_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int C_PTR_W = $clog2(DEPTH);

  logic [C_PTR_W:0]   r_wr_ptr;
  logic [C_PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_push_en;
  logic               w_pop_en;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_en = i_push && (!o_full || i_pop);
  assign w_pop_en  = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[C_PTR_W] != r_rd_ptr[C_PTR_W]) &&
                   (r_wr_ptr[C_PTR_W-1:0] == r_rd_ptr[C_PTR_W-1:0]);
  assign o_head  = r_mem[r_rd_ptr[C_PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr[C_PTR_W-1:0]] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/bwt_occ_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bwt_occ_responder                                          |
// | Fetches the k/l occurrence lines of a buffered request through one   |
// | in-order read port and returns them paired with the request tag.     |
// | Option  : SMEM_OCC_SAME_LINE_DEDUP_EN - single fetch when k == l.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bwt_occ_responder
  import smem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_k,
  input  logic [ADDR_W-1:0] req_addr_l,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LINE_W-1:0] rsp_data_k,
  output logic [LINE_W-1:0] rsp_data_l,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              err_unexp
);

  localparam int C_ENTRY_W = 2 * ADDR_W + TAG_W;

  occ_state_e          r_state;
  logic                r_live;
  logic [ADDR_W-1:0]   r_addr_k;
  logic [ADDR_W-1:0]   r_addr_l;
  logic [TAG_W-1:0]    r_tag;
  logic [1:0]          r_rcnt;
  logic                r_mem_rd_valid;
  logic [ADDR_W-1:0]   r_mem_rd_addr;
  logic                r_rsp_valid;
  logic [LINE_W-1:0]   r_data_k;
  logic [LINE_W-1:0]   r_data_l;
  logic                r_err_unexp;

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_push;
  logic                w_pop;
  logic [C_ENTRY_W-1:0] w_push_entry;
  logic [C_ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]   w_head_k;
  logic [ADDR_W-1:0]   w_head_l;
  logic [TAG_W-1:0]    w_head_tag;
  logic                w_dedup;
  logic [1:0]          w_needed;
  logic                w_rsp_open;
  logic                w_rsp_acc;
  logic [1:0]          w_rcnt_nxt;

  // r_live holds req_ready low through reset and the first cycle after it.
  assign req_ready    = r_live && !w_fifo_full;
  assign w_push       = req_valid && req_ready;
  assign w_pop        = (r_state == IDLE) && !w_fifo_empty;
  assign w_push_entry = {req_addr_k, req_addr_l, req_tag};

  assign w_head_k   = w_head[C_ENTRY_W-1 -: ADDR_W];
  assign w_head_l   = w_head[TAG_W +: ADDR_W];
  assign w_head_tag = w_head[TAG_W-1:0];

`ifdef SMEM_OCC_SAME_LINE_DEDUP_EN
  assign w_dedup = (r_addr_k == r_addr_l);
`else
  assign w_dedup = 1'b0;
`endif

  assign w_needed = w_dedup ? C_RCNT_SINGLE : C_RCNT_PAIR;

  // The k line may land while the l command is still stalled in ISSUE_L.
  assign w_rsp_open = ((r_state == ISSUE_L) || (r_state == WAIT)) && (r_rcnt < w_needed);
  assign w_rsp_acc  = mem_rsp_valid && w_rsp_open;
  assign w_rcnt_nxt = w_rsp_acc ? rcnt_inc(r_rcnt, w_needed) : r_rcnt;

  occ_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (C_ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_live         <= 1'b0;
      r_addr_k       <= '0;
      r_addr_l       <= '0;
      r_tag          <= '0;
      r_rcnt         <= '0;
      r_mem_rd_valid <= 1'b0;
      r_mem_rd_addr  <= '0;
      r_rsp_valid    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_rcnt <= w_rcnt_nxt;
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            r_addr_k       <= w_head_k;
            r_addr_l       <= w_head_l;
            r_tag          <= w_head_tag;
            r_rcnt         <= '0;
            r_mem_rd_valid <= 1'b1;
            r_mem_rd_addr  <= w_head_k;
            r_state        <= ISSUE_K;
          end
        end
        ISSUE_K: begin
          if (mem_rd_ready) begin
            if (w_dedup) begin
              r_mem_rd_valid <= 1'b0;
              r_state        <= WAIT;
            end else begin
              r_mem_rd_addr <= r_addr_l;
              r_state       <= ISSUE_L;
            end
          end
        end
        ISSUE_L: begin
          if (mem_rd_ready) begin
            r_mem_rd_valid <= 1'b0;
            r_state        <= WAIT;
          end
        end
        WAIT: begin
          // Count the response landing this cycle so the pair leaves one cycle earlier.
          if (w_rcnt_nxt == w_needed) begin
            r_rsp_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_mem_rd_valid <= 1'b0;
          r_rsp_valid    <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_k    <= '0;
      r_data_l    <= '0;
      r_err_unexp <= 1'b0;
    end else begin
      if (w_rsp_acc) begin
        if (r_rcnt == 2'd0) begin
          r_data_k <= mem_rsp_data;
          if (w_dedup) r_data_l <= mem_rsp_data;
        end else begin
          r_data_l <= mem_rsp_data;
        end
      end
      if (mem_rsp_valid && !w_rsp_acc) r_err_unexp <= 1'b1;
    end
  end

  assign mem_rd_valid = r_mem_rd_valid;
  assign mem_rd_addr  = r_mem_rd_addr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data_k   = r_data_k;
  assign rsp_data_l   = r_data_l;
  assign rsp_tag      = r_tag;
  assign err_unexp    = r_err_unexp;

endmodule
`default_nettype wire

// File: tb/tb_bwt_occ_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bwt_occ_responder                                       |
// | Scoreboard bench: one-cycle memory model, in-order response checker. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bwt_occ_responder;

  localparam int ADDR_W = 42;
  localparam int LINE_W = 512;
  localparam int TAG_W  = 16;
  localparam int DEPTH  = 4;
  localparam logic [ADDR_W-1:0] C_STALL_K = 42'h300;

`ifdef SMEM_OCC_SAME_LINE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] dk;
    logic [LINE_W-1:0] dl;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr_k;
  logic [ADDR_W-1:0] req_addr_l;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ready;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [LINE_W-1:0] rsp_data_k;
  logic [LINE_W-1:0] rsp_data_l;
  logic [TAG_W-1:0]  rsp_tag;
  logic              err_unexp;

  exp_t              sb[$];
  logic [ADDR_W-1:0] exp_cmd[$];
  int                cmd_cyc[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int cmd_cnt = 0;
  int last_rsp_cyc = -1;
  int stall_cnt = 0;
  bit drop_rsp = 1'b0;
  bit inject_stray = 1'b0;

  bwt_occ_responder #(
    .ADDR_W (ADDR_W), .LINE_W (LINE_W), .TAG_W (TAG_W), .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr_k    (req_addr_k),
    .req_addr_l    (req_addr_l),
    .req_tag       (req_tag),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_ready  (mem_rd_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data_k    (rsp_data_k),
    .rsp_data_l    (rsp_data_l),
    .rsp_tag       (rsp_tag),
    .err_unexp     (err_unexp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LINE_W-1:0] mdata(input logic [ADDR_W-1:0] a);
    return {16{(a[15:0] ^ 16'h5A00), a[15:0]}};
  endfunction

  task automatic check(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: samples the command at negedge, answers for one cycle starting just after the edge.
  initial begin
    bit                fire;
    logic [ADDR_W-1:0] a;
    mem_rd_ready  = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire = mem_rd_valid && mem_rd_ready;
      a    = mem_rd_addr;
      if (fire) begin
        cmd_cnt++;
        cmd_cyc.push_back(cyc);
        if (exp_cmd.size() == 0) check("mem_cmd_unexpected", {470'd0, a}, '1);
        else check("mem_cmd_addr", {470'd0, a}, {470'd0, exp_cmd.pop_front()});
        if (a == C_STALL_K) stall_cnt = 3;
      end
      @(posedge clk);
      #1;
      mem_rd_ready = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      if (fire && !drop_rsp) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mdata(a);
      end else if (inject_stray) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = '1;
        inject_stray  = 1'b0;
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check("rsp_unexpected_tag", {496'd0, rsp_tag}, '1);
        end else begin
          e = sb.pop_front();
          check("rsp_tag", {496'd0, rsp_tag}, {496'd0, e.tag});
          check("rsp_data_k", rsp_data_k, e.dk);
          check("rsp_data_l", rsp_data_l, e.dl);
        end
      end
    end
  end

  task automatic push(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l,
                      input logic [TAG_W-1:0] tag, input bit want_rsp, input bit want_cmd,
                      output int t_acc);
    exp_t e;
    bit   done;
    done = 1'b0;
    t_acc = -1;
    req_addr_k = k;
    req_addr_l = l;
    req_tag    = tag;
    req_valid  = 1'b1;
    if (want_cmd) begin
      exp_cmd.push_back(k);
      if (!(DEDUP && (k == l))) exp_cmd.push_back(l);
    end
    if (want_rsp) begin
      e.tag = tag;
      e.dk  = mdata(k);
      e.dl  = mdata(l);
      sb.push_back(e);
    end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        done  = 1'b1;
        t_acc = cyc;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: req_ready low for tag %0h, expected acceptance", tag);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({nm, "_drain_outstanding"}, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int base;
    int c0;
    int c1;
    bit done;
    rst = 1'b0;
    req_valid = 1'b0;
    req_addr_k = '0;
    req_addr_l = '0;
    req_tag = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_mem_rd_valid", mem_rd_valid, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_err_unexp", err_unexp, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single request, ideal memory: latency and command order.
    cmd_cyc.delete();
    base = cmd_cnt;
    push(42'h100, 42'h180, 16'h002A, 1'b1, 1'b1, t);
    drain("t1");
    c0 = (cmd_cyc.size() > 0) ? cmd_cyc[0] : -100;
    c1 = (cmd_cyc.size() > 1) ? cmd_cyc[1] : -100;
    check("t1_cmd_count", cmd_cnt - base, 2);
    check("t1_k_cmd_cycle", c0 - t, 2);
    check("t1_l_cmd_cycle", c1 - t, 3);
    check("t1_rsp_latency", last_rsp_cyc - t, 5);

    // Five back-to-back requests with downstream stalled.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(42'h1000 + 42'(i * 64), 42'h1020 + 42'(i * 64), 16'h0011 + 16'(i), 1'b1, 1'b1, t);
    repeat (3) @(posedge clk);
    #1;
    check("t2_req_ready_full", req_ready, 0);
    check("t2_rsp_valid_held", rsp_valid, 1);
    check("t2_rsp_tag_held", {496'd0, rsp_tag}, 512'h11);
    rsp_ready = 1'b1;
    drain("t2");

    // l command stalled while the k line returns.
    cmd_cyc.delete();
    push(C_STALL_K, 42'h380, 16'h0033, 1'b1, 1'b1, t);
    drain("t3");
    c0 = (cmd_cyc.size() > 0) ? cmd_cyc[0] : -100;
    c1 = (cmd_cyc.size() > 1) ? cmd_cyc[1] : -100;
    check("t3_l_after_stall", c1 - c0, 4);

    // Same line for k and l.
    base = cmd_cnt;
    push(42'h200, 42'h200, 16'h0044, 1'b1, 1'b1, t);
    drain("t4");
    check("t4_same_line_cmds", cmd_cnt - base, DEDUP ? 1 : 2);

    // Stray response while idle is flagged and sticks.
    inject_stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_err_set", err_unexp, 1);
    push(42'h500, 42'h540, 16'h0055, 1'b1, 1'b1, t);
    drain("t5");
    check("t5_err_sticky", err_unexp, 1);

    // Reset while waiting on memory, with a second request buffered.
    drop_rsp = 1'b1;
    base = cmd_cnt;
    push(42'h600, 42'h640, 16'h0066, 1'b0, 1'b1, t);
    push(42'h700, 42'h740, 16'h0077, 1'b0, 1'b0, t);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      if (cmd_cnt >= base + 2) done = 1'b1;
    end
    check("t6_cmds_before_reset", cmd_cnt - base, 2);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6_rst_req_ready", req_ready, 0);
    check("t6_rst_mem_rd_valid", mem_rd_valid, 0);
    check("t6_rst_mem_rd_addr", {470'd0, mem_rd_addr}, 0);
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_rsp_tag", {496'd0, rsp_tag}, 0);
    check("t6_rst_rsp_data_k", rsp_data_k, 0);
    check("t6_rst_err_unexp", err_unexp, 0);
    drop_rsp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    base = cmd_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("t6_ready_after_reset", req_ready, 1);
    check("t6_fifo_empty_no_cmds", cmd_cnt - base, 0);
    inject_stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_stale_rsp_err", err_unexp, 1);
    check("end_cmds_outstanding", exp_cmd.size(), 0);
    check("end_rsps_outstanding", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
